pcie_tx_arb: RTL

Parametrised N-channel arbiter for the 16-bit VC0 transmit interface of the ECP3 PCIe core. It sits between the core's tx_req/tx_rdy/tx_st/tx_end/tx_data port and several TLP sources inside pciedma, such as the DMA engine, completion generator and MSI/status writer. It replaces the single-source wiring. The arbiter serialises whole TLPs with round-robin fairness and never interleaves beats. A watchdog recovers the link port when a source stalls mid-TLP.

---
 rtl/pcie_pkg.sv | 14 +
 rtl/rr_pick.sv | 35 +++
 rtl/pcie_tx_arb.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/pcie_pkg.sv
// rtl/pcie_pkg.sv - shared types and constants for the PCIe transmit path
package pcie_pkg;

    // Default beat width of the VC0 transmit interface.
    localparam int TLP_DW = 16;

    // Transmit arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } tx_arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority encoder
//   req   : request vector, one bit per channel
//   ptr   : channel with highest priority this cycle (search starts here)
//   idx   : first requesting channel at or after ptr, modulo N
//   valid : at least one request bit is set
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW:0] cand;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        cand  = '0;
        for (int i = 0; i < N; i++) begin
            // One extra bit holds ptr+i before the modulo-N fold.
            cand = {1'b0, ptr} + (IW+1)'(i);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!valid && req[cand[IW-1:0]]) begin
                valid = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/pcie_tx_arb.sv
// rtl/pcie_tx_arb.sv - N-channel whole-TLP arbiter for the VC0 transmit port
//   pcie_clk / sys_rst : single clock, synchronous active-high reset
//   ch_req/ch_gnt      : per-channel request, one-cycle combinational grant
//   ch_st/ch_end/ch_data : per-channel beat stream, channel i at [i*DW +: DW]
//   tx_req/tx_rdy/tx_st/tx_end/tx_data : core transmit port
//   busy / cur_ch / err_timeout : status, owner channel, watchdog abort pulse
//   PCIE_TXARB_PRIO_EN : when defined, channel 0 has strict priority
module pcie_tx_arb
    import pcie_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int DW        = TLP_DW,
    parameter int MAX_BEATS = 512
) (
    input  logic                   pcie_clk,
    input  logic                   sys_rst,
    input  logic [NCH-1:0]         ch_req,
    output logic [NCH-1:0]         ch_gnt,
    input  logic [NCH-1:0]         ch_st,
    input  logic [NCH-1:0]         ch_end,
    input  logic [NCH*DW-1:0]      ch_data,
    output logic                   tx_req,
    input  logic                   tx_rdy,
    output logic                   tx_st,
    output logic                   tx_end,
    output logic [DW-1:0]          tx_data,
    output logic                   busy,
    output logic [$clog2(NCH)-1:0] cur_ch,
    output logic                   err_timeout
);

    localparam int CW   = $clog2(NCH);
    localparam int CNTW = $clog2(MAX_BEATS + 1);

    tx_arb_state_e   state_q, state_d;
    logic [CW-1:0]   cur_ch_q, cur_ch_d;
    logic [CW-1:0]   last_ch_q, last_ch_d;
    logic [CNTW-1:0] beat_cnt_q, beat_cnt_d;
    logic            err_timeout_q, err_timeout_d;

    logic [NCH-1:0]  rr_req;
    logic [CW-1:0]   rr_ptr, rr_idx, win_ch;
    logic            rr_valid, win_valid;
    logic            sel_st, sel_end, wd_expire;
    logic [DW-1:0]   sel_data;

    // Search starts one past the last owner so it drops to lowest priority.
    assign rr_ptr = (last_ch_q == CW'(NCH - 1)) ? '0 : last_ch_q + CW'(1);

`ifdef PCIE_TXARB_PRIO_EN
    // Channel 0 is handled outside the rotation.
    assign rr_req = {ch_req[NCH-1:1], 1'b0};
`else
    assign rr_req = ch_req;
`endif

    rr_pick #(
        .N  (NCH),
        .IW (CW)
    ) u_rr_pick (
        .req   (rr_req),
        .ptr   (rr_ptr),
        .idx   (rr_idx),
        .valid (rr_valid)
    );

    always_comb begin
`ifdef PCIE_TXARB_PRIO_EN
        if (ch_req[0]) begin
            win_valid = 1'b1;
            win_ch    = '0;
        end else begin
            win_valid = rr_valid;
            win_ch    = rr_idx;
        end
`else
        win_valid = rr_valid;
        win_ch    = rr_idx;
`endif
    end

    // Selected channel's beat signals.
    always_comb begin
        sel_st   = 1'b0;
        sel_end  = 1'b0;
        sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (cur_ch_q == CW'(i)) begin
                sel_st   = ch_st[i];
                sel_end  = ch_end[i];
                sel_data = ch_data[i*DW +: DW];
            end
        end
    end

    // The counter holds completed XFER cycles, so the current cycle is the
    // MAX_BEATS-th one when it reads MAX_BEATS-1.
    assign wd_expire = (beat_cnt_q == CNTW'(MAX_BEATS - 1));

    always_comb begin
        state_d       = state_q;
        cur_ch_d      = cur_ch_q;
        last_ch_d     = last_ch_q;
        beat_cnt_d    = beat_cnt_q;
        err_timeout_d = 1'b0;
        ch_gnt        = '0;
        tx_req        = 1'b0;
        tx_st         = 1'b0;
        tx_end        = 1'b0;
        tx_data       = '0;

        case (state_q)
            IDLE: begin
                if (win_valid) begin
                    cur_ch_d = win_ch;
                    state_d  = REQ;
                end
            end
            REQ: begin
                tx_req = 1'b1;
                if (tx_rdy) begin
                    ch_gnt[cur_ch_q] = 1'b1;
                    beat_cnt_d       = '0;
                    state_d          = XFER;
                end
            end
            XFER: begin
                tx_st   = sel_st;
                tx_data = sel_data;
                tx_end  = sel_end | wd_expire;
                if (beat_cnt_q < CNTW'(MAX_BEATS)) begin
                    beat_cnt_d = beat_cnt_q + CNTW'(1);
                end
                if (sel_end || wd_expire) begin
                    last_ch_d     = cur_ch_q;
                    state_d       = IDLE;
                    // A genuine end on the expiry cycle is not an abort.
                    err_timeout_d = ~sel_end;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pcie_clk) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            cur_ch_q      <= '0;
            last_ch_q     <= CW'(NCH - 1);
            beat_cnt_q    <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cur_ch_q      <= cur_ch_d;
            last_ch_q     <= last_ch_d;
            beat_cnt_q    <= beat_cnt_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign cur_ch      = cur_ch_q;
    assign err_timeout = err_timeout_q;

endmodule
